// File: rtl/led_display_row_driver_if.sv
// ============================================================================
// led_display_row_driver_if
// Row stream between the pattern generator and the LED row driver.
// Row layout (MSB first): top.red, top.green, top.blue, bot.red, bot.green,
// bot.blue, each NUM_COL_PIXELS wide, bit c = column c.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_display_row_driver_if #(
    parameter int NUM_COL_PIXELS = 64
);
    localparam int GL_RGB_ROW_W = 6 * NUM_COL_PIXELS;

    logic [GL_RGB_ROW_W-1:0] row_in;
    logic                    row_valid_in;
    logic                    row_ready_out;
    logic [3:0]              row_address_in;

    modport master (
        output row_in,
        output row_valid_in,
        output row_address_in,
        input  row_ready_out
    );

    modport slave (
        input  row_in,
        input  row_valid_in,
        input  row_address_in,
        output row_ready_out
    );
endinterface

`default_nettype wire

// File: rtl/led_display_row_driver.sv
// ============================================================================
// led_display_row_driver
// Captures one top/bottom row pair and serialises it onto HUB75-style panel
// pins, then blanks, latches and displays the row before asking for the next.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_display_row_driver #(
    parameter int SYS_CLK_FREQ     = 100_000_000,
    parameter int NUM_COL_PIXELS   = 64,
    parameter int BCLK_HALF_PERIOD = 2,
    parameter int BLANK_CYCLES     = 4,
    parameter int DISPLAY_CYCLES   = 256
) (
    input  wire logic                  clk_in,
    input  wire logic                  reset_in,
    led_display_row_driver_if.slave    row_port,
    output logic                       bclk_out,
    output logic [2:0]                 rgb_top_out,
    output logic [2:0]                 rgb_bot_out,
    output logic                       latch_out,
    output logic                       n_oe_out,
    output logic [3:0]                 address_out
);

    localparam int N         = NUM_COL_PIXELS;
    localparam int COL_W     = (N > 1) ? $clog2(N) : 1;
    localparam int PH_W      = (BCLK_HALF_PERIOD > 1) ? $clog2(BCLK_HALF_PERIOD) : 1;
    localparam int DWELL_MAX = (BLANK_CYCLES > DISPLAY_CYCLES) ? BLANK_CYCLES : DISPLAY_CYCLES;
    localparam int DW_W      = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(N - 1);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(BCLK_HALF_PERIOD - 1);
    localparam logic [DW_W-1:0]  BLANK_LAST = DW_W'(BLANK_CYCLES - 1);
    localparam logic [DW_W-1:0]  DISP_LAST  = DW_W'(DISPLAY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_next;
    logic [PH_W-1:0]  phase;
    logic [DW_W-1:0]  dwell;
    logic [3:0]       pending_address;
    logic [N-1:0]     buf_tr, buf_tg, buf_tb, buf_br, buf_bg, buf_bb;

    // SYS_CLK_FREQ is informational only; this tie-off marks it as intentionally unreferenced.
    logic unused_sys_clk_freq;
    assign unused_sys_clk_freq = (SYS_CLK_FREQ != 0);

    assign col_next = col + COL_W'(1);

    // Row capture, bit-clock serialisation and blank/latch/display sequencing.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state                  <= IDLE;
            row_port.row_ready_out <= 1'b0;
            bclk_out               <= 1'b0;
            rgb_top_out            <= 3'b000;
            rgb_bot_out            <= 3'b000;
            latch_out              <= 1'b0;
            n_oe_out               <= 1'b1;
            address_out            <= 4'd0;
            col                    <= '0;
            phase                  <= '0;
            dwell                  <= '0;
            pending_address        <= 4'd0;
            {buf_tr, buf_tg, buf_tb, buf_br, buf_bg, buf_bb} <= '0;
        end else begin
            case (state)
                IDLE: begin
                    n_oe_out  <= 1'b1;
                    bclk_out  <= 1'b0;
                    latch_out <= 1'b0;
                    if (row_port.row_ready_out && row_port.row_valid_in) begin
                        row_port.row_ready_out <= 1'b0;
                        {buf_tr, buf_tg, buf_tb, buf_br, buf_bg, buf_bb} <= row_port.row_in;
                        pending_address <= row_port.row_address_in;
                        col             <= '0;
                        phase           <= '0;
                        // Column 0 goes out straight from the bus so the low
                        // phase of the first column starts on the accept edge.
                        rgb_top_out <= {row_port.row_in[5*N], row_port.row_in[4*N],
                                        row_port.row_in[3*N]};
                        rgb_bot_out <= {row_port.row_in[2*N], row_port.row_in[N],
                                        row_port.row_in[0]};
                        state <= SHIFT;
                    end else begin
                        row_port.row_ready_out <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        if (!bclk_out) begin
                            bclk_out <= 1'b1;
                        end else if (col == COL_LAST) begin
                            bclk_out    <= 1'b0;
                            dwell       <= '0;
                            address_out <= pending_address;
                            state       <= BLANK;
                        end else begin
                            bclk_out    <= 1'b0;
                            col         <= col_next;
                            rgb_top_out <= {buf_tr[col_next], buf_tg[col_next], buf_tb[col_next]};
                            rgb_bot_out <= {buf_br[col_next], buf_bg[col_next], buf_bb[col_next]};
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end

                BLANK: begin
                    if (dwell == BLANK_LAST) begin
                        dwell     <= '0;
                        latch_out <= 1'b1;
                        state     <= LATCH;
                    end else begin
                        dwell <= dwell + DW_W'(1);
                    end
                end

                LATCH: begin
                    latch_out <= 1'b0;
                    n_oe_out  <= 1'b0;
                    dwell     <= '0;
                    state     <= DISPLAY;
                end

                DISPLAY: begin
                    if (dwell == DISP_LAST) begin
                        dwell                  <= '0;
                        n_oe_out               <= 1'b1;
                        row_port.row_ready_out <= 1'b1;
                        state                  <= IDLE;
                    end else begin
                        dwell <= dwell + DW_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_display_row_driver.sv
// ============================================================================
// tb_led_display_row_driver
// Self-checking bench: directed row table, back-to-back, backpressure,
// mid-shift reset, random rows, and a fast-parameter variant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_display_row_driver;

    localparam int N  = 64;
    localparam int H0 = 2, B0 = 4, D0 = 256;
    localparam int H1 = 1, B1 = 1, D1 = 1;
    localparam int T0 = 2*H0*N + B0 + 1 + D0;
    localparam int T1 = 2*H1*N + B1 + 1 + D1;
    // {ready, bclk, top[2:0], bot[2:0], latch, n_oe, address[3:0]}
    localparam logic [13:0] RST_VEC   = 14'h0010;
    localparam logic [13:0] READY_VEC = 14'h2010;

    typedef struct packed {
        logic [63:0] tr, tg, tb, br, bg, bb;
    } row_t;

    typedef struct {
        row_t       row;
        logic [3:0] addr;
        int         col_a;
        logic [2:0] top_a, bot_a;
        int         col_b;
        logic [2:0] top_b, bot_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic valid;
    row_t row_bus;
    logic [3:0] addr_bus;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [3:0] cur_addr;
    logic [2:0] cap_top [64];
    logic [2:0] cap_bot [64];
    row_t bp_row, bp_row2;

    led_display_row_driver_if #(.NUM_COL_PIXELS(N)) if0 ();
    led_display_row_driver_if #(.NUM_COL_PIXELS(N)) if1 ();

    assign if0.row_in         = row_bus;
    assign if1.row_in         = row_bus;
    assign if0.row_address_in = addr_bus;
    assign if1.row_address_in = addr_bus;
    assign if0.row_valid_in   = valid & ~sel;
    assign if1.row_valid_in   = valid & sel;

    logic       bclk0, latch0, noe0, bclk1, latch1, noe1;
    logic [2:0] top0, bot0, top1, bot1;
    logic [3:0] adr0, adr1;

    led_display_row_driver #(
        .SYS_CLK_FREQ(100_000_000), .NUM_COL_PIXELS(N),
        .BCLK_HALF_PERIOD(H0), .BLANK_CYCLES(B0), .DISPLAY_CYCLES(D0)
    ) dut0 (
        .clk_in(clk), .reset_in(rst), .row_port(if0.slave),
        .bclk_out(bclk0), .rgb_top_out(top0), .rgb_bot_out(bot0),
        .latch_out(latch0), .n_oe_out(noe0), .address_out(adr0)
    );

    led_display_row_driver #(
        .SYS_CLK_FREQ(100_000_000), .NUM_COL_PIXELS(N),
        .BCLK_HALF_PERIOD(H1), .BLANK_CYCLES(B1), .DISPLAY_CYCLES(D1)
    ) dut1 (
        .clk_in(clk), .reset_in(rst), .row_port(if1.slave),
        .bclk_out(bclk1), .rgb_top_out(top1), .rgb_bot_out(bot1),
        .latch_out(latch1), .n_oe_out(noe1), .address_out(adr1)
    );

    logic [13:0] vec0, vec1, act;
    assign vec0 = {if0.row_ready_out, bclk0, top0, bot0, latch0, noe0, adr0};
    assign vec1 = {if1.row_ready_out, bclk1, top1, bot1, latch1, noe1, adr1};
    assign act  = sel ? vec1 : vec0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: panel pin values k cycles after the accept edge.
    function automatic logic [13:0] model(input int k, input row_t r, input logic [3:0] a,
                                          input logic [3:0] pa, input int h, input int b,
                                          input int d);
        int sl, t, c;
        logic bc, rdy, lat, noe;
        logic [3:0] ad;
        logic [5:0] ci;
        sl  = 2*h*N;
        t   = sl + b + 1 + d;
        c   = (k < sl) ? k / (2*h) : N - 1;
        ci  = c[5:0];
        bc  = (k < sl) && ((k % (2*h)) >= h);
        rdy = (k == t);
        lat = (k == sl + b);
        noe = !((k > sl + b) && (k < t));
        ad  = (k >= sl) ? a : pa;
        return {rdy, bc, r.tr[ci], r.tg[ci], r.tb[ci], r.br[ci], r.bg[ci], r.bb[ci], lat, noe, ad};
    endfunction

    function automatic row_t rand_row();
        row_t r;
        r.tr = {$urandom, $urandom}; r.tg = {$urandom, $urandom}; r.tb = {$urandom, $urandom};
        r.br = {$urandom, $urandom}; r.bg = {$urandom, $urandom}; r.bb = {$urandom, $urandom};
        return r;
    endfunction

    function automatic vec_t mk(input row_t r, input logic [3:0] a,
                                input int ca, input logic [2:0] ta, input logic [2:0] ba,
                                input int cb, input logic [2:0] tb, input logic [2:0] bb);
        vec_t v;
        v.row = r; v.addr = a;
        v.col_a = ca; v.top_a = ta; v.bot_a = ba;
        v.col_b = cb; v.top_b = tb; v.bot_b = bb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain row; 1: backpressure injections during the row; 2: reset in column 30
    task automatic check_row(input row_t r, input logic [3:0] a, input int mode, input bit hold,
                             output int waited, output int acc_cyc, output bit aborted);
        int h, b, d, sl, t, rises, lats;
        logic pb, rdy;
        bit acc;
        logic [13:0] e;
        h = sel ? H1 : H0;
        b = sel ? B1 : B0;
        d = sel ? D1 : D0;
        sl = 2*h*N;
        t = sl + b + 1 + d;
        aborted = 0; rises = 0; lats = 0; waited = 0; acc = 0; acc_cyc = 0; pb = 1'b0;
        row_bus = r; addr_bus = a; valid = 1'b1;
        while (!acc && waited < 3000) begin
            rdy = act[13];
            step();
            waited++;
            acc = rdy;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 3000 cycles");
            valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        if (!hold) valid = 1'b0;
        for (int k = 0; k <= t; k++) begin
            if (k > 0) step();
            e = model(k, r, a, cur_addr, h, b, d);
            chk($sformatf("row_a%0d_k%0d", a, k), act, e);
            if (act[12] && !pb) begin
                if (rises < 64) begin
                    cap_top[rises] = act[11:9];
                    cap_bot[rises] = act[8:6];
                end
                rises++;
            end
            pb = act[12];
            if (act[5]) lats++;
            if (mode == 1 && k == 10) begin
                row_bus = bp_row; addr_bus = 4'd9; valid = 1'b1;
            end
            if (mode == 1 && k == 11) valid = 1'b0;
            if (mode == 1 && k == 200) begin
                row_bus = bp_row2; addr_bus = 4'd3; valid = 1'b1;
            end
            if (mode == 2 && k == 2*h*30 + 1) begin
                rst = 1'b1;
                #1;
                chk("reset_mid_shift_immediate", act, RST_VEC);
                aborted = 1;
                break;
            end
        end
        if (aborted) return;
        chk("bclk_rises", rises, N);
        chk("latch_pulses", lats, 1);
        cur_addr = a;
    endtask

    // Panel-level invariants checked on every cycle.
    logic [3:0] mon_addr = 4'd0;
    logic       mon_noe  = 1'b1;
    always @(posedge clk) begin
        #1;
        if (act[5]) begin
            checks++;
            if (!act[4]) begin
                errors++;
                $display("FAIL latch_with_oe: got latch=1 n_oe=0 expected n_oe=1");
            end
        end
        if (act[3:0] !== mon_addr) begin
            checks++;
            if (!(act[4] && mon_noe)) begin
                errors++;
                $display("FAIL addr_change_while_lit: got %0h->%0h n_oe %b/%b expected n_oe 1/1",
                         mon_addr, act[3:0], mon_noe, act[4]);
            end
        end
        mon_addr = act[3:0];
        mon_noe  = act[4];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        row_t r;
        int w, ac, prev_ac;
        bit ab;
        logic [3:0] a4;

        rst = 1'b1; sel = 1'b0; valid = 1'b0; row_bus = '0; addr_bus = 4'd0; cur_addr = 4'd0;
        repeat (2) step();
        chk("reset_dut0", vec0, RST_VEC);
        chk("reset_dut1", vec1, RST_VEC);
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("ready_after_reset_dut0", vec0, READY_VEC);
        chk("ready_after_reset_dut1", vec1, READY_VEC);

        // Directed table: row pattern, address, two probed columns with expected rgb.
        r = '0; r.tr = '1; r.bb = 64'hAAAA_AAAA_AAAA_AAAA;
        vecs[0] = mk(r, 4'd5, 0, 3'b100, 3'b000, 1, 3'b100, 3'b001);
        r = '0; r.tg = '1; r.br = 64'h1;
        vecs[1] = mk(r, 4'd15, 0, 3'b010, 3'b100, 63, 3'b010, 3'b000);
        r = '0; r.tb = 64'h8000_0000_0000_0000; r.bg = 64'hFFFF_FFFF_0000_0000;
        vecs[2] = mk(r, 4'd0, 63, 3'b001, 3'b010, 31, 3'b000, 3'b000);
        r = '1;
        vecs[3] = mk(r, 4'd9, 40, 3'b111, 3'b111, 0, 3'b111, 3'b111);

        for (int i = 0; i < 4; i++) begin
            check_row(vecs[i].row, vecs[i].addr, 0, 1'b0, w, ac, ab);
            chk($sformatf("tbl%0d_top_col%0d", i, vecs[i].col_a), cap_top[vecs[i].col_a], vecs[i].top_a);
            chk($sformatf("tbl%0d_bot_col%0d", i, vecs[i].col_a), cap_bot[vecs[i].col_a], vecs[i].bot_a);
            chk($sformatf("tbl%0d_top_col%0d", i, vecs[i].col_b), cap_top[vecs[i].col_b], vecs[i].top_b);
            chk($sformatf("tbl%0d_bot_col%0d", i, vecs[i].col_b), cap_bot[vecs[i].col_b], vecs[i].bot_b);
        end

        // Back-to-back with valid held: addresses 0..15 then 0.
        prev_ac = 0;
        for (int i = 0; i < 17; i++) begin
            a4 = 4'(i % 16);
            check_row(rand_row(), a4, 0, (i < 16), w, ac, ab);
            if (i > 0) chk("b2b_accept_spacing", ac - prev_ac, T0 + 1);
            prev_ac = ac;
        end
        valid = 1'b0;

        // Backpressure: address 9 pulsed mid-shift is ignored; address 3 waits for IDLE.
        bp_row = rand_row();
        bp_row2 = rand_row();
        check_row(rand_row(), 4'd7, 1, 1'b0, w, ac, ab);
        check_row(bp_row2, 4'd3, 0, 1'b0, w, ac, ab);
        chk("bp_accept_first_idle_edge", w, 1);

        // Reset during column 30, then a full clean row.
        check_row(rand_row(), 4'd12, 2, 1'b0, w, ac, ab);
        step();
        chk("reset_held", act, RST_VEC);
        rst = 1'b0;
        step();
        chk("ready_after_mid_reset", act, READY_VEC);
        cur_addr = 4'd0;
        check_row(rand_row(), 4'd6, 0, 1'b0, w, ac, ab);

        // Random rows with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) step();
            a4 = 4'($urandom_range(0, 15));
            check_row(rand_row(), a4, 0, 1'b0, w, ac, ab);
        end

        // Fast-parameter variant, back-to-back.
        sel = 1'b1;
        cur_addr = 4'd0;
        step();
        prev_ac = 0;
        for (int i = 0; i < 4; i++) begin
            a4 = 4'($urandom_range(0, 15));
            check_row(rand_row(), a4, 0, (i < 3), w, ac, ab);
            if (i > 0) chk("variant_accept_spacing", ac - prev_ac, T1 + 1);
            prev_ac = ac;
        end
        valid = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
